// File: rtl/aes_pkg.sv
// Shared AES sequencer definitions: round count, round-index width,
// block type and the sequencer state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int RC_W       = 4;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller. It performs the initial
// AddRoundKey and then drives one external round unit through NUM_ROUNDS
// rounds. The state and round-key registers feed the round unit directly.
// The final round is flagged so the round unit can skip MixColumns.
module aes_round_sequencer
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plaintext_in,
  input  logic [127:0]    key_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    ciphertext_out,
  output logic            rnd_start,
  output logic [RC_W-1:0] rnd_rc,
  output logic            rnd_final,
  output logic [127:0]    rnd_data,
  output logic [127:0]    rnd_key,
  input  logic            rnd_done,
  input  logic [127:0]    rnd_data_in,
  input  logic [127:0]    rnd_key_in,
  output logic            busy
);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS - 1);
  localparam logic [RC_W-1:0] RC_ZERO = {RC_W{1'b0}};

  seq_state_t      state_r;
  seq_state_t      state_nxt_s;
  logic            accept_s;
  logic            round_ret_s;
  logic [RC_W-1:0] rc_inc_s;

  // A block is taken only in IDLE. A returning round only counts in WAIT,
  // so any rnd_done seen in another state is ignored.
  assign accept_s    = (state_r == IDLE) && in_valid;
  assign round_ret_s = (state_r == WAIT) && rnd_done;
  assign rc_inc_s    = rnd_rc + RC_W'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. ISSUE always lasts exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = ISSUE;
        else          state_nxt_s = IDLE;
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (rnd_done) state_nxt_s = rnd_final ? DONE : ISSUE;
        else          state_nxt_s = WAIT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs that are decoded directly from the state flops.
  always_comb begin
    in_ready  = 1'b0;
    rnd_start = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ISSUE:   rnd_start = 1'b1;
      WAIT:    rnd_start = 1'b0;
      DONE:    rnd_start = 1'b0;
      default: busy      = 1'b1;
    endcase
  end

  // Round state, round key, round index and final-round flag.
  // The final flag is precomputed whenever the index changes, so it is
  // already valid during ISSUE and stays stable through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_data  <= 128'd0;
      rnd_key   <= 128'd0;
      rnd_rc    <= RC_ZERO;
      rnd_final <= 1'b0;
    end else if (accept_s) begin
      rnd_data  <= plaintext_in ^ key_in;
      rnd_key   <= key_in;
      rnd_rc    <= RC_ZERO;
      rnd_final <= (RC_ZERO == RC_LAST);
    end else if (round_ret_s && !rnd_final) begin
      rnd_data  <= rnd_data_in;
      rnd_key   <= rnd_key_in;
      rnd_rc    <= rc_inc_s;
      rnd_final <= (rc_inc_s == RC_LAST);
    end else begin
      rnd_data  <= rnd_data;
      rnd_key   <= rnd_key;
      rnd_rc    <= rnd_rc;
      rnd_final <= rnd_final;
    end
  end

  // Result register and output valid, held until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ciphertext_out <= 128'd0;
      out_valid      <= 1'b0;
    end else if (round_ret_s && rnd_final) begin
      ciphertext_out <= rnd_data_in;
      out_valid      <= 1'b1;
    end else if ((state_r == DONE) && out_ready) begin
      ciphertext_out <= ciphertext_out;
      out_valid      <= 1'b0;
    end else begin
      ciphertext_out <= ciphertext_out;
      out_valid      <= out_valid;
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller. It drives a single shared round unit through 10 rounds instead of instantiating an unrolled chain of rounds. The block accepts plaintext and key with a valid/ready handshake and performs the initial AddRoundKey. It then issues rounds with the correct round-constant index, flags the final round, and presents the ciphertext with a valid/ready handshake. It sits between the host interface and the round unit; the round unit does SubBytes/ShiftRows/MixColumns/AddRoundKey and key expansion.

Parameters:
NUM_ROUNDS, 10, total rounds issued; the last one is flagged final.
RC_W, 4, width of the round-constant index.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  plaintext/key present.
in_ready  out  1  sequencer can accept a new block.
plaintext_in  in  128  plaintext block.
key_in  in  128  cipher key.
out_valid  out  1  ciphertext valid.
out_ready  in  1  consumer accepts ciphertext.
ciphertext_out  out  128  result block.
rnd_start  out  1  round issue strobe to the round unit.
rnd_rc  out  RC_W  round index 0..NUM_ROUNDS-1; the round unit maps it to Rcon.
rnd_final  out  1  current round omits MixColumns.
rnd_data  out  128  state register fed to the round unit.
rnd_key  out  128  current round-key register fed to the round unit.
rnd_done  in  1  round unit result valid, 1-cycle pulse.
rnd_data_in  in  128  round output state.
rnd_key_in  in  128  next round key from the round unit.
busy  out  1  a block is in flight (any state other than IDLE).

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state flops.
- Reset (async, any time, including mid-operation):
  - state = IDLE; out_valid = 0; ciphertext_out = 0; rnd_start = 0; rnd_rc = 0; rnd_final = 0; rnd_data = 0; rnd_key = 0; busy = 0.
  - An in-flight block is discarded and no out_valid is ever produced for it.
- in_ready = (state == IDLE). It is 1 in the first cycle after rst deasserts.
- IDLE: on in_valid & in_ready at an edge:
  - rnd_data <= plaintext_in ^ key_in; rnd_key <= key_in; rnd_rc <= 0; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rnd_start = 1.
  - rnd_final = (rnd_rc == NUM_ROUNDS-1).
  - Go to WAIT.
- WAIT: hold rnd_data, rnd_key, rnd_rc, rnd_final stable.
  - On rnd_done, if not final: rnd_data <= rnd_data_in; rnd_key <= rnd_key_in; rnd_rc <= rnd_rc+1; go to ISSUE.
  - On rnd_done, if final: ciphertext_out <= rnd_data_in; out_valid <= 1; go to DONE. rnd_key is not updated.
- DONE: hold ciphertext_out and out_valid while out_ready = 0.
  - On out_ready: out_valid <= 0; go to IDLE.
  - in_ready stays 0 in DONE; the next block is accepted no earlier than the cycle after the output handshake.
- rnd_done outside WAIT (IDLE, ISSUE, DONE) is ignored and has no state change.
- rnd_done in the same cycle the block enters WAIT counts (WAIT is evaluated on the next edge).
- rnd_start is never asserted twice without an intervening rnd_done.
- rnd_rc never exceeds NUM_ROUNDS-1 and never wraps. The counter resets to 0 only on acceptance or reset.
- Latency with a round unit that returns rnd_done one cycle after rnd_start:
  - Accept edge at cycle 0; ISSUE at cycles 1, 3, …, 19; final rnd_done at cycle 20; out_valid first high in cycle 21.
  - General formula: NUM_ROUNDS*(L+1)+1 cycles, where L is the round-unit latency.
- in_valid held while busy has no effect; inputs are sampled only at acceptance.

Decomposition:
- Shared package aes_pkg holds:
  - NUM_ROUNDS and RC_W constants.
  - 128-bit block/key typedef.
  - Sequencer state enum {IDLE, ISSUE, WAIT, DONE}.
- Single flat module, no sub-module: FSM, round counter and three 128-bit registers.
- The round unit stays an external instance (aes_round_unit), connected at the next level up.

Test Plan:
- FIPS-197 C.1 vector with a behavioural 1-cycle round unit: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid first in cycle 21 after accept.
- FIPS-197 B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check the observed rnd_rc sequence is 0..9 and rnd_final is high only while rnd_rc = 9.
- Backpressure: hold out_ready = 0 for 7 cycles after out_valid -> ciphertext and out_valid stable, in_ready = 0, busy = 1; on out_ready = 1, IDLE and in_ready = 1 the next cycle.
- Reset mid-operation: assert rst during WAIT at rnd_rc = 5 -> all outputs read 0 immediately. Then submit the C.1 vector -> correct ciphertext with rnd_rc restarting at 0.
- Spurious/slow done: inject rnd_done pulses in IDLE and DONE, and use a round unit with 3-cycle latency -> no state change from the spurious pulses, correct ciphertext, out_valid at cycle 41.
- Back-to-back blocks with in_valid held high -> second accept one cycle after the first output handshake; both ciphertexts correct and in order.
